// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// uart_rx_param : oversampling UART receiver with baud tick generator, input
//                 synchroniser and valid/ready output holding register
// rev 1.0
// ============================================================================
module uart_rx_param #(
  parameter int NB_DATA     = 8,
  parameter int BAUD_DIV    = 163,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int NB_STOP     = 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_parity_err,
  output logic               o_frame_err,
  output logic               o_overrun
);

  localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(NB_DATA + 1);

  localparam logic [TW-1:0] TICK_LAST  = TW'(BAUD_DIV - 1);
  localparam logic [SW-1:0] HALF_LAST  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] BIT_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] DATA_LAST  = NW'(NB_DATA - 1);
  localparam logic [NW-1:0] STOP_LAST  = NW'(NB_STOP - 1);
  localparam logic          PAR_ODD    = (PARITY_MODE == 2);
  localparam logic          HAS_PARITY = (PARITY_MODE != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [TW-1:0] tcnt_q;
  logic          tick;

  assign tick = (tcnt_q == TICK_LAST);

  always_ff @(posedge i_clock) begin
    if (i_reset)   tcnt_q <= '0;
    else if (tick) tcnt_q <= '0;
    else           tcnt_q <= tcnt_q + 1'b1;
  end

  logic [1:0] sync_q;
  logic       rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge i_clock) begin
    if (i_reset) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], i_rx};
  end

  state_t             state_q, state_d;
  logic [SW-1:0]      s_cnt_q, s_cnt_d;
  logic [NW-1:0]      n_cnt_q, n_cnt_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic               armed_q, armed_d;
  logic               par_err_q, par_err_d;
  logic               frm_err_q, frm_err_d;
  logic               done;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      s_cnt_q   <= '0;
      n_cnt_q   <= '0;
      shift_q   <= '0;
      armed_q   <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_cnt_q   <= s_cnt_d;
      n_cnt_q   <= n_cnt_d;
      shift_q   <= shift_d;
      armed_q   <= armed_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    s_cnt_d   = s_cnt_q;
    n_cnt_d   = n_cnt_q;
    shift_d   = shift_q;
    armed_d   = armed_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A start edge only counts once the line has been seen idle-high.
        if (rx_s) armed_d = 1'b1;
        if (armed_q && !rx_s) begin
          state_d = S_START;
          s_cnt_d = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (s_cnt_q == HALF_LAST) begin
            if (!rx_s) begin
              state_d   = S_DATA;
              s_cnt_d   = '0;
              n_cnt_d   = '0;
              par_err_d = 1'b0;
              frm_err_d = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d = '0;
            shift_d = {rx_s, shift_q[NB_DATA-1:1]};
            if (n_cnt_q == DATA_LAST) begin
              n_cnt_d = '0;
              state_d = HAS_PARITY ? S_PARITY : S_STOP;
            end else begin
              n_cnt_d = n_cnt_q + 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d   = '0;
            par_err_d = (((^shift_q) ^ rx_s) != PAR_ODD);
            state_d   = S_STOP;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d = '0;
            if (!rx_s) frm_err_d = 1'b1;
            if (n_cnt_q == STOP_LAST) begin
              done    = 1'b1;
              n_cnt_d = '0;
              armed_d = 1'b0;
              state_d = S_IDLE;
            end else begin
              n_cnt_d = n_cnt_q + 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [NB_DATA-1:0] data_q;
  logic               valid_q, perr_q, ferr_q, ovr_q;

  // frm_err_d is used on load so the final stop sample is included.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (done) begin
      if (valid_q && !i_ready) begin
        ovr_q <= 1'b1;
      end else begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
        perr_q  <= par_err_q;
        ferr_q  <= frm_err_d;
      end
    end else if (valid_q && i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_overrun    = ovr_q;

endmodule
`default_nettype wire
